// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg -- definitions shared by the CNN datapath blocks.
//
// Contents:
//   CNN_WIDTH  default signed sample width used across the layers
//   cnn_xfer   valid/ready handshake: a transfer happens when both are high
// ---------------------------------------------------------------------------
package cnn_pkg;

    localparam int CNN_WIDTH = 16;

    function automatic logic cnn_xfer(input logic valid, input logic ready);
        return valid && ready;
    endfunction

endpackage

// File: rtl/maxpool_out_fifo.sv
// ---------------------------------------------------------------------------
// maxpool_out_fifo -- 2-entry FIFO holding pooled results with their
// end-of-frame flag.
//
// Ports:
//   clk      clock, rising edge
//   reset    synchronous active-low reset; clears pointers, count, contents
//   push_i   write data_i (caller never pushes when count_o == 2)
//   data_i   entry to write
//   pop_i    retire head entry (caller never pops when count_o == 0)
//   data_o   head entry
//   count_o  occupancy 0..2
// ---------------------------------------------------------------------------
module maxpool_out_fifo #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem0_q;
    logic [W-1:0] mem1_q;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push_i;
        rd_ptr_d = rd_ptr_q ^ pop_i;
        count_d  = count_q;
        // Push and pop together leave the occupancy unchanged.
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i) begin
                if (wr_ptr_q) mem1_q <= data_i;
                else          mem0_q <= data_i;
            end
        end
    end

    assign data_o  = rd_ptr_q ? mem1_q : mem0_q;
    assign count_o = count_q;

endmodule

// File: rtl/maxpool_24_2_16.sv
// ---------------------------------------------------------------------------
// maxpool_24_2_16 -- 1-D max pooling (window = stride = POOL) over frames of
// LENX signed samples, with valid/ready streaming on both sides.
//
// A running maximum is kept per window; when a window closes (POOL samples,
// or the last sample of the frame for a trailing partial window) the pooled
// value is queued in a 2-entry output FIFO together with an end-of-frame flag.
//
// Ports:
//   clk           clock, rising edge
//   reset         synchronous active-low reset
//   s_data_in_x   signed input sample        s_valid_x / s_ready_x  handshake
//   m_data_out_y  signed pooled result       m_valid_y / m_ready_y  handshake
//   m_last_y      high with the final pooled result of a frame
//
// Build option:
//   MAXPOOL_RELU_EN  when defined, negative pooled values are written as 0.
// ---------------------------------------------------------------------------
module maxpool_24_2_16
    import cnn_pkg::*;
#(
    parameter int WIDTH = CNN_WIDTH,
    parameter int LENX  = 24,
    parameter int POOL  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] s_data_in_x,
    input  logic                    s_valid_x,
    output logic                    s_ready_x,
    output logic signed [WIDTH-1:0] m_data_out_y,
    output logic                    m_valid_y,
    input  logic                    m_ready_y,
    output logic                    m_last_y
);

    // Counters are at least one bit wide so POOL == 1 / LENX == 1 still build.
    localparam int WIN_W = (POOL > 1) ? $clog2(POOL) : 1;
    localparam int FRM_W = (LENX > 1) ? $clog2(LENX) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(POOL - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(LENX - 1);

    function automatic logic signed [WIDTH-1:0] smax(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

`ifdef MAXPOOL_RELU_EN
    function automatic logic signed [WIDTH-1:0] relu(input logic signed [WIDTH-1:0] a);
        return (a < 0) ? '0 : a;
    endfunction
`endif

    logic [WIN_W-1:0]        win_q, win_d;
    logic [FRM_W-1:0]        frm_q, frm_d;
    logic signed [WIDTH-1:0] max_q, max_d;
    logic                    in_xfer;
    logic                    out_xfer;
    logic                    frm_end;
    logic                    win_close;
    logic signed [WIDTH-1:0] pooled;
    logic signed [WIDTH-1:0] wr_val;
    logic [1:0]              fifo_count;
    logic [WIDTH:0]          fifo_din;
    logic [WIDTH:0]          fifo_dout;

    assign s_ready_x = reset && (fifo_count < 2'd2);
    assign in_xfer   = cnn_xfer(s_valid_x, s_ready_x);
    assign frm_end   = (frm_q == FRM_LAST);
    assign win_close = (win_q == WIN_LAST) || frm_end;

    // The first sample of a window replaces whatever the register held.
    assign pooled = (win_q == '0) ? s_data_in_x : smax(max_q, s_data_in_x);

`ifdef MAXPOOL_RELU_EN
    assign wr_val = relu(pooled);
`else
    assign wr_val = pooled;
`endif

    always_comb begin
        win_d = win_q;
        frm_d = frm_q;
        max_d = max_q;
        if (in_xfer) begin
            max_d = pooled;
            win_d = win_close ? '0 : win_q + WIN_W'(1);
            frm_d = frm_end   ? '0 : frm_q + FRM_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            win_q <= '0;
            frm_q <= '0;
            max_q <= '0;
        end else begin
            win_q <= win_d;
            frm_q <= frm_d;
            max_q <= max_d;
        end
    end

    assign fifo_din = {frm_end, wr_val};
    assign out_xfer = cnn_xfer(m_valid_y, m_ready_y);

    maxpool_out_fifo #(
        .W (WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_xfer && win_close),
        .data_i  (fifo_din),
        .pop_i   (out_xfer),
        .data_o  (fifo_dout),
        .count_o (fifo_count)
    );

    assign m_valid_y    = (fifo_count != 2'd0);
    assign m_data_out_y = fifo_dout[WIDTH-1:0];
    assign m_last_y     = fifo_dout[WIDTH];

endmodule
